// File: rtl/sysarr_fifo_ctrl.sv
// Sequencer for the per-row input FIFOs of a systolic array edge: steers incoming
// rows into their FIFO and drains the FIFOs with diagonally skewed shift strobes.
module sysarr_fifo_ctrl #(
   parameter int N     = 4,
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               nRST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_row,
   output logic [N-1:0]       fifo_load,
   output logic [N*WIDTH-1:0] fifo_load_values,
   output logic [N-1:0]       fifo_shift,
   input  logic               array_ready,
   output logic               feed_active,
   output logic [1:0]         mat_count,
   output logic               done
);

   localparam int TW = $clog2(2 * N);
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam logic [TW-1:0] T_LAST  = TW'(2 * N - 2);
   localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

   typedef enum logic {
      IDLE,
      FEED
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [TW-1:0]   t;
   logic [TW-1:0]   t_next;
   logic [RW-1:0]   row_idx;
   logic [1:0]      mat_next;
   logic            accept;
   logic            mat_inc;

   // Ready is held low while nRST is asserted so nothing is accepted during reset.
   assign in_ready         = nRST && (mat_count < 2'd2);
   assign accept           = in_valid && in_ready;
   assign mat_inc          = accept && (row_idx == ROW_LAST);
   assign fifo_load_values = in_row;
   assign feed_active      = (state == FEED);
   assign done             = (state == FEED) && (t == T_LAST);
   assign mat_next         = mat_count + 2'(mat_inc) - 2'(done);

   always_comb begin
      fifo_load = '0;
      if (accept) begin
         fifo_load[row_idx] = 1'b1;
      end
   end

   // Row i is active for N cycles starting at t == i, giving the diagonal skew.
   always_comb begin
      fifo_shift = '0;
      for (int i = 0; i < N; i++) begin
         fifo_shift[i] = feed_active && (int'(t) >= i) && (int'(t) < i + N);
      end
   end

   always_comb begin
      state_next = state;
      t_next     = t;
      case (state)
         IDLE: begin
            if ((mat_count != 2'd0) && array_ready) begin
               state_next = FEED;
               t_next     = '0;
            end
         end
         FEED: begin
            if (done) begin
               t_next     = '0;
               state_next = ((mat_next != 2'd0) && array_ready) ? FEED : IDLE;
            end else begin
               t_next = t + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            t_next     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         t         <= '0;
         row_idx   <= '0;
         mat_count <= 2'd0;
      end else begin
         state     <= state_next;
         t         <= t_next;
         mat_count <= mat_next;
         if (accept) begin
            row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sysarr_fifo_ctrl.sv
// Directed bench for sysarr_fifo_ctrl: per-cycle expectations are queued as each
// step is driven and popped for comparison once the outputs have settled.
module tb_sysarr_fifo_ctrl;

   localparam int N     = 4;
   localparam int WIDTH = 16;

   logic               clk = 1'b0;
   logic               nRST;
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] in_row;
   logic [N-1:0]       fifo_load;
   logic [N*WIDTH-1:0] fifo_load_values;
   logic [N-1:0]       fifo_shift;
   logic               array_ready;
   logic               feed_active;
   logic [1:0]         mat_count;
   logic               done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] load;
      logic [3:0] shift;
      logic       feed;
      logic       done;
      logic [1:0] mat;
      logic       ready;
   } exp_t;

   exp_t               exp_q[$];
   logic [N*WIDTH-1:0] row_q[$];
   logic [3:0]         shift_seq [7];

   sysarr_fifo_ctrl #(.N(N), .WIDTH(WIDTH)) dut (
      .clk              (clk),
      .nRST             (nRST),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_row           (in_row),
      .fifo_load        (fifo_load),
      .fifo_load_values (fifo_load_values),
      .fifo_shift       (fifo_shift),
      .array_ready      (array_ready),
      .feed_active      (feed_active),
      .mat_count        (mat_count),
      .done             (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] ld, input logic [3:0] sh, input logic fd,
                               input logic dn, input logic [1:0] mc, input logic rd);
      exp_t e;
      e.load  = ld;
      e.shift = sh;
      e.feed  = fd;
      e.done  = dn;
      e.mat   = mc;
      e.ready = rd;
      return e;
   endfunction

   task automatic check_output();
      exp_t               e;
      logic [N*WIDTH-1:0] r;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 64'd1, 64'd0);
         return;
      end
      e = exp_q.pop_front();
      r = row_q.pop_front();
      chk("fifo_load",   64'(fifo_load),   64'(e.load));
      chk("fifo_shift",  64'(fifo_shift),  64'(e.shift));
      chk("feed_active", 64'(feed_active), 64'(e.feed));
      chk("done",        64'(done),        64'(e.done));
      chk("mat_count",   64'(mat_count),   64'(e.mat));
      chk("in_ready",    64'(in_ready),    64'(e.ready));
      chk("load_values", fifo_load_values, r);
   endtask

   // Drive one cycle's inputs after the falling edge, then sample before the rising edge.
   task automatic apply_stimulus(input logic v, input logic ar, input exp_t e);
      @(negedge clk);
      in_valid    = v;
      array_ready = ar;
      in_row      = {$urandom, $urandom};
      exp_q.push_back(e);
      row_q.push_back(in_row);
      #2;
      check_output();
   endtask

   task automatic feed_matrix(input logic v, input logic ar_last, input logic [1:0] mc,
                              input logic rd);
      for (int k = 0; k < 7; k++) begin
         apply_stimulus(v, (k == 6) ? ar_last : 1'b1,
                        mk(4'b0000, shift_seq[k], 1'b1, k == 6, mc, rd));
      end
   endtask

   initial begin
      shift_seq[0] = 4'b0001; shift_seq[1] = 4'b0011; shift_seq[2] = 4'b0111;
      shift_seq[3] = 4'b1111; shift_seq[4] = 4'b1110; shift_seq[5] = 4'b1100;
      shift_seq[6] = 4'b1000;

      nRST        = 1'b0;
      in_valid    = 1'b1;
      array_ready = 1'b0;
      in_row      = '0;
      @(negedge clk);
      chk("rst_in_ready",   64'(in_ready),    64'd0);
      chk("rst_fifo_load",  64'(fifo_load),   64'd0);
      chk("rst_fifo_shift", 64'(fifo_shift),  64'd0);
      chk("rst_feed",       64'(feed_active), 64'd0);
      chk("rst_mat",        64'(mat_count),   64'd0);
      chk("rst_done",       64'(done),        64'd0);
      nRST     = 1'b1;
      in_valid = 1'b0;

      // Single matrix with the array ready.
      apply_stimulus(1, 1, mk(4'b0001, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 1, mk(4'b0010, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 1, mk(4'b0100, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 1, mk(4'b1000, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 1, mk(4'b0000, 4'b0, 0, 0, 2'd1, 1));
      feed_matrix(0, 1, 2'd1, 1);
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));

      // Back-pressure: two matrices buffered, ninth row held off.
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(1, 0, mk(4'(1 << (k % 4)), 4'b0, 0, 0, (k < 4) ? 2'd0 : 2'd1, 1));
      end
      apply_stimulus(1, 0, mk(4'b0000, 4'b0, 0, 0, 2'd2, 0));
      apply_stimulus(1, 0, mk(4'b0000, 4'b0, 0, 0, 2'd2, 0));
      apply_stimulus(1, 1, mk(4'b0000, 4'b0, 0, 0, 2'd2, 0));
      feed_matrix(1, 0, 2'd2, 0);
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd1, 1));

      // Array stalled with one matrix buffered, then a single-cycle array_ready.
      for (int k = 0; k < 10; k++) begin
         apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd1, 1));
      end
      apply_stimulus(0, 1, mk(4'b0000, 4'b0, 0, 0, 2'd1, 1));
      for (int k = 0; k < 7; k++) begin
         apply_stimulus(0, 0, mk(4'b0000, shift_seq[k], 1, k == 6, 2'd1, 1));
      end
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));

      // Overlap: second matrix streams in during the first FEED and chains straight on.
      apply_stimulus(1, 1, mk(4'b0001, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 1, mk(4'b0010, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 1, mk(4'b0100, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 1, mk(4'b1000, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 1, mk(4'b0000, 4'b0, 0, 0, 2'd1, 1));
      for (int k = 0; k < 7; k++) begin
         apply_stimulus(k >= 3, 1, mk((k >= 3) ? 4'(1 << (k - 3)) : 4'b0000, shift_seq[k],
                                      1, k == 6, 2'd1, 1));
      end
      feed_matrix(0, 0, 2'd1, 1);
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));

      // Gapped input: loads only on valid cycles.
      apply_stimulus(1, 0, mk(4'b0001, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 0, mk(4'b0010, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 0, mk(4'b0100, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(1, 0, mk(4'b1000, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 1, mk(4'b0000, 4'b0, 0, 0, 2'd1, 1));

      // Reset asserted mid-FEED at t=3.
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(0, 1, mk(4'b0000, shift_seq[k], 1, 0, 2'd1, 1));
      end
      in_valid = 1'b1;
      #1;
      nRST = 1'b0;
      #1;
      chk("mid_rst_fifo_load",  64'(fifo_load),   64'd0);
      chk("mid_rst_fifo_shift", 64'(fifo_shift),  64'd0);
      chk("mid_rst_feed",       64'(feed_active), 64'd0);
      chk("mid_rst_done",       64'(done),        64'd0);
      chk("mid_rst_mat",        64'(mat_count),   64'd0);
      chk("mid_rst_in_ready",   64'(in_ready),    64'd0);
      @(negedge clk);
      nRST     = 1'b1;
      in_valid = 1'b0;
      apply_stimulus(1, 0, mk(4'b0001, 4'b0, 0, 0, 2'd0, 1));
      apply_stimulus(0, 0, mk(4'b0000, 4'b0, 0, 0, 2'd0, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sysarr_fifo_ctrl.md
Name: sysarr_fifo_ctrl

Overview:
- Sequencer for the N per-row input FIFOs (sysarr_FIFO instances) that feed one edge of the systolic array.
- Accepts matrix rows over a valid/ready handshake and steers each row into the correct FIFO via one-hot load strobes.
- When the array is ready, drives skewed (diagonal) shift strobes so row i enters the array i cycles after row 0.
- Tracks up to two buffered matrices, so loading the next matrix overlaps feeding of the current one.

Parameters:
- N, 4, array dimension; number of row FIFOs and elements per row.
- WIDTH, 16, bits per element.

Ports:
- clk  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  controller can accept a row.
- in_row  in  N*WIDTH  row data; element k at [k*WIDTH +: WIDTH].
- fifo_load  out  N  one-hot load strobe; bit i loads FIFO i.
- fifo_load_values  out  N*WIDTH  broadcast copy of in_row to all FIFOs.
- fifo_shift  out  N  per-FIFO shift (pop) strobe.
- array_ready  in  1  array can begin consuming a matrix.
- feed_active  out  1  high during every FEED cycle.
- mat_count  out  2  matrices fully loaded and not yet fully fed (0..2).
- done  out  1  one-cycle pulse on the final FEED cycle of a matrix.

Behaviour:
- Reset values:
  - in_ready=0 only during reset, then 1.
  - fifo_load=0, fifo_shift=0, feed_active=0, mat_count=0, done=0.
  - Row index=0, feed counter=0, feeder state=IDLE.
- Loader:
  - in_ready = (mat_count < 2), from registered mat_count only.
  - Accept = in_valid & in_ready.
  - On accept: fifo_load = 1<<row_idx (combinational, same cycle); fifo_load_values = in_row always.
  - row_idx increments on accept; at N-1 it wraps to 0 and mat_count increments.
  - in_valid gaps hold row_idx; no timeout.
- Feeder FSM, states IDLE and FEED; counter t, width $clog2(2N), range 0..2N-2.
  - IDLE -> FEED when mat_count >= 1 && array_ready; t <= 0. First FEED cycle is the cycle after the condition is sampled.
  - FEED: fifo_shift[i] = (t >= i) && (t < i+N), decoded from registered t/state only (no input-to-shift path). feed_active=1.
  - array_ready is ignored inside FEED; there is no stall, and the matrix runs to completion.
  - At t = 2N-2: done=1 and mat_count decrements. Next state is FEED with t=0 if (mat_count after update) >= 1 && array_ready; otherwise IDLE.
  - Otherwise t increments each cycle.
- Simultaneous mat_count increment (last row accepted) and decrement (done): net unchanged.
- A FIFO may receive load and shift in the same cycle. The FIFO applies load then shift.
- Per-FIFO occupancy never exceeds 2N because at most one complete matrix plus one in-flight matrix is held.
- mat_count saturates by construction: increments are impossible when it is 2 because in_ready=0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A partially loaded matrix is discarded. FIFOs are reset by the same nRST.
- Per-matrix feed latency: 2N-1 cycles. Each FIFO receives exactly N shifts per matrix.

Test Plan:
- Single matrix, N=4, array_ready=1: 4 rows accepted on consecutive cycles give fifo_load=0001,0010,0100,1000. mat_count reaches 1. Next 7 cycles fifo_shift = 0001,0011,0111,1111,1110,1100,1000; done on the 7th; mat_count returns to 0.
- Back-pressure, array_ready=0: 8 rows accepted, then mat_count=2 and in_ready=0. A 9th in_valid is held with no fifo_load. Raising array_ready starts FEED the next cycle, and in_ready returns to 1 after the first done.
- Overlap: second matrix streamed during the first FEED; mat_count stays 1 when increment and decrement coincide. The feeder chains straight into a second FEED (t=0) with no IDLE cycle; 14 consecutive feed_active cycles.
- Gapped input: in_valid toggling 1,0,0,1,1,0,1 loads rows 0..3 only on valid cycles; fifo_load stays 0 in gaps.
- Reset mid-FEED at t=3: all outputs are 0 asynchronously. After release, mat_count=0, and a fresh matrix gives fifo_load=0001 on its first row.
- Array stalled: mat_count=1 and array_ready=0 for 10 cycles gives no fifo_shift. Asserting array_ready for 1 cycle starts the full 7-cycle FEED even if it drops again.
